dmem_arbiter: RTL and testbench

//  Shares the single-port 2048x32 data memory between the CPU data port and a DMA/loader port.
//  - CPU has default priority.
//  - DMA wins immediately when the CPU is idle.
//  - A DMA starved for MAX_WAIT cycles takes a locked burst of up to BURST_MAX beats while the CPU stalls.
//  - Sits between the CPU memory stage / DMA engine and the data memory macro (async read, byte-lane write on posedge clk).

---
 rtl/dmem_arbiter.sv | 170 +++++++++++++++++
 tb/tb_dmem_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Arbiter sharing the single-port data memory between the CPU data port and a DMA/loader port.
// The CPU wins by default; a starved DMA request takes a locked burst while the CPU stalls.
module dmem_arbiter #(
    parameter int ADDR_W    = 11,
    parameter int MAX_WAIT  = 8,
    parameter int BURST_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_en,
    input  logic [3:0]        cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_stall,
    input  logic              dma_req,
    input  logic [3:0]        dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [31:0]       dma_wdata,
    output logic              dma_ack,
    output logic [31:0]       dma_rdata,
    output logic              dma_rvalid,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam int BEAT_W = $clog2(BURST_MAX + 1);

    typedef enum logic {
        CPU_OWN = 1'b0,
        DMA_OWN = 1'b1
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [WAIT_W-1:0]  wait_cnt_r;
    logic [WAIT_W-1:0]  wait_nxt_s;
    logic [BEAT_W-1:0]  beat_cnt_r;
    logic [BEAT_W-1:0]  beat_nxt_s;
    logic               starve_s;
    logic               dma_gnt_s;
    logic               cpu_gnt_s;
    logic [31:0]        dma_rdata_r;
    logic               dma_rvalid_r;

    // Grant decision, stall and next-state / counter update
    always_comb begin
        state_nxt_s = state_r;
        wait_nxt_s  = wait_cnt_r;
        beat_nxt_s  = beat_cnt_r;
        dma_gnt_s   = 1'b0;
        cpu_gnt_s   = 1'b0;
        cpu_stall   = 1'b0;
        starve_s    = (wait_cnt_r >= WAIT_W'(MAX_WAIT));
        if (!rst_n) begin
            state_nxt_s = CPU_OWN;
            wait_nxt_s  = '0;
            beat_nxt_s  = '0;
        end else begin
            case (state_r)
                CPU_OWN: begin
                    if (dma_req && (!cpu_en || starve_s)) begin
                        dma_gnt_s  = 1'b1;
                        cpu_stall  = cpu_en;
                        wait_nxt_s = '0;
                        if (cpu_en) begin
                            // Forced grant: first beat of a locked burst
                            beat_nxt_s = BEAT_W'(1);
                            if (BURST_MAX == 1) begin
                                state_nxt_s = CPU_OWN;
                            end else begin
                                state_nxt_s = DMA_OWN;
                            end
                        end else begin
                            beat_nxt_s = beat_cnt_r;
                        end
                    end else begin
                        cpu_gnt_s = cpu_en;
                        if (!dma_req) begin
                            wait_nxt_s = '0;
                        end else if (wait_cnt_r < WAIT_W'(MAX_WAIT)) begin
                            wait_nxt_s = wait_cnt_r + WAIT_W'(1);
                        end else begin
                            wait_nxt_s = wait_cnt_r;
                        end
                    end
                end
                DMA_OWN: begin
                    cpu_stall = cpu_en;
                    if (dma_req) begin
                        dma_gnt_s = 1'b1;
                        if ((beat_cnt_r + BEAT_W'(1)) == BEAT_W'(BURST_MAX)) begin
                            state_nxt_s = CPU_OWN;
                            beat_nxt_s  = '0;
                            wait_nxt_s  = '0;
                        end else begin
                            beat_nxt_s = beat_cnt_r + BEAT_W'(1);
                        end
                    end else begin
                        state_nxt_s = CPU_OWN;
                        beat_nxt_s  = '0;
                        wait_nxt_s  = '0;
                    end
                end
                default: begin
                    state_nxt_s = CPU_OWN;
                    wait_nxt_s  = '0;
                    beat_nxt_s  = '0;
                end
            endcase
        end
    end

    // Memory bus mux: only the granted side reaches memory, otherwise the bus idles at zero
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 4'b0000;
        mem_addr  = '0;
        mem_wdata = 32'h0000_0000;
        dma_ack   = dma_gnt_s;
        cpu_rdata = mem_rdata;
        if (dma_gnt_s) begin
            mem_en    = 1'b1;
            mem_we    = dma_we;
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
        end else if (cpu_gnt_s) begin
            mem_en    = 1'b1;
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else begin
            mem_en = 1'b0;
        end
    end

    // Arbiter state and counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= CPU_OWN;
            wait_cnt_r <= '0;
            beat_cnt_r <= '0;
        end else begin
            state_r    <= state_nxt_s;
            wait_cnt_r <= wait_nxt_s;
            beat_cnt_r <= beat_nxt_s;
        end
    end

    // DMA read return: capture data of an accepted read beat, pulse valid for one cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dma_rdata_r  <= 32'h0000_0000;
            dma_rvalid_r <= 1'b0;
        end else if (dma_gnt_s && (dma_we == 4'b0000)) begin
            dma_rdata_r  <= mem_rdata;
            dma_rvalid_r <= 1'b1;
        end else begin
            dma_rvalid_r <= 1'b0;
        end
    end

    assign dma_rdata  = dma_rdata_r;
    assign dma_rvalid = dma_rvalid_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: stimulus pushes per-cycle expectations, a monitor
// on the falling edge pops and compares them against the DUT and a behavioural memory.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_en;
    logic [3:0]  cpu_we;
    logic [10:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        dma_req;
    logic [3:0]  dma_we;
    logic [10:0] dma_addr;
    logic [31:0] dma_wdata;
    logic        dma_ack;
    logic [31:0] dma_rdata;
    logic        dma_rvalid;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [10:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic        pre_we = 1'b0;
    logic [10:0] pre_addr = 11'h000;
    logic [31:0] pre_data = 32'h0;
    logic [31:0] mem [0:2047];

    typedef struct {
        logic [7:0] v;
        logic       z;
        string      nm;
    } rec_t;
    typedef struct {
        logic [10:0] a;
        logic [31:0] d;
        string       nm;
    } mchk_t;

    rec_t        cyc_q[$];
    logic [31:0] rd_q[$];
    mchk_t       mchk_q[$];
    logic        zchk_next = 1'b0;
    logic        done = 1'b0;
    int          total = 0;
    int          bad = 0;

    dmem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_en(cpu_en), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_ack(dma_ack), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural memory: async read, byte-lane write (bit3 -> [7:0] ... bit0 -> [31:24])
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end else if (mem_en) begin
            if (mem_we[3]) mem[mem_addr][7:0]   <= mem_wdata[7:0];
            if (mem_we[2]) mem[mem_addr][15:8]  <= mem_wdata[15:8];
            if (mem_we[1]) mem[mem_addr][23:16] <= mem_wdata[23:16];
            if (mem_we[0]) mem[mem_addr][31:24] <= mem_wdata[31:24];
        end
    end

    task automatic drive(input logic r, input logic ce, input logic [3:0] cw, input logic [10:0] ca,
                         input logic [31:0] cd, input logic dr, input logic [3:0] dw,
                         input logic [10:0] da, input logic [31:0] dd);
        rst_n = r; cpu_en = ce; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dd;
    endtask

    // Expected {dma_ack, cpu_stall, mem_en, mem_we, dma_rvalid} for the current cycle
    task automatic step(input logic a, input logic s, input logic m, input logic [3:0] w,
                        input logic rv, input string nm);
        rec_t r;
        r.v = {a, s, m, w, rv};
        r.z = zchk_next;
        r.nm = nm;
        cyc_q.push_back(r);
        zchk_next = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [10:0] a, input logic [31:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(posedge clk);
        #1;
        pre_we = 1'b0;
    endtask

    task automatic mcheck(input logic [10:0] a, input logic [31:0] d, input string nm);
        mchk_t m;
        m.a = a; m.d = d; m.nm = nm;
        mchk_q.push_back(m);
    endtask

    // Monitor: compare DUT outputs against queued expectations away from the active edge
    always @(negedge clk) begin
        rec_t        e;
        mchk_t       mc;
        logic [7:0]  got;
        logic [31:0] x;
        if (cyc_q.size() > 0) begin
            e = cyc_q.pop_front();
            got = {dma_ack, cpu_stall, mem_en, mem_we, dma_rvalid};
            total++;
            if (got !== e.v) begin
                bad++;
                $display("FAIL %s: ack/stall/en/we/rv got %b required %b", e.nm, got, e.v);
            end
            if (e.z) begin
                total++;
                if (dma_rdata !== 32'h0) begin
                    bad++;
                    $display("FAIL %s_rdata0: got %h required 00000000", e.nm, dma_rdata);
                end
            end
        end
        if (dma_rvalid === 1'b1) begin
            total++;
            if (rd_q.size() == 0) begin
                bad++;
                $display("FAIL rdata_unexpected: got rvalid with %h, none required", dma_rdata);
            end else begin
                x = rd_q.pop_front();
                if (dma_rdata !== x) begin
                    bad++;
                    $display("FAIL rdata: got %h required %h", dma_rdata, x);
                end
            end
        end
        if (mchk_q.size() > 0) begin
            mc = mchk_q.pop_front();
            total++;
            if (mem[mc.a] !== mc.d) begin
                bad++;
                $display("FAIL %s: mem[%h] got %h required %h", mc.nm, mc.a, mem[mc.a], mc.d);
            end
        end
        if (done) begin
            total++;
            if (rd_q.size() != 0 || cyc_q.size() != 0) begin
                bad++;
                $display("FAIL leftover: rdata queue %0d cycle queue %0d required 0 0",
                         rd_q.size(), cyc_q.size());
            end
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        drive(1'b0, 1'b0, 4'h0, 11'h000, 32'h0, 1'b0, 4'h0, 11'h000, 32'h0);
        @(posedge clk);
        #1;
        preload(11'h010, 32'hDEADBEEF);
        preload(11'h020, 32'hA0A0A0A0);
        preload(11'h021, 32'hA1A1A1A1);
        preload(11'h022, 32'hA2A2A2A2);
        preload(11'h023, 32'hA3A3A3A3);
        preload(11'h7FF, 32'h00000000);

        // Reset holds the bus idle even with both sides requesting
        drive(1'b0, 1'b1, 4'hF, 11'h003, 32'h12345678, 1'b1, 4'h0, 11'h010, 32'h0);
        step(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, "rst_a");
        zchk_next = 1'b1;
        step(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, "rst_b");

        // Opportunistic DMA read, then DMA write
        drive(1'b1, 1'b0, 4'h0, 11'h000, 32'h0, 1'b1, 4'h0, 11'h010, 32'h0);
        rd_q.push_back(32'hDEADBEEF);
        step(1'b1, 1'b0, 1'b1, 4'h0, 1'b0, "t1_acc");
        drive(1'b1, 1'b0, 4'h0, 11'h000, 32'h0, 1'b1, 4'hF, 11'h040, 32'h55555555);
        step(1'b1, 1'b0, 1'b1, 4'hF, 1'b1, "dwr_acc");
        drive(1'b1, 1'b0, 4'h0, 11'h000, 32'h0, 1'b0, 4'h0, 11'h000, 32'h0);
        mcheck(11'h040, 32'h55555555, "dwr_mem");
        step(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, "dwr_norv");

        // CPU full-word write to the top address
        drive(1'b1, 1'b1, 4'hF, 11'h7FF, 32'h11111111, 1'b0, 4'h0, 11'h000, 32'h0);
        step(1'b0, 1'b0, 1'b1, 4'hF, 1'b0, "cwr");
        drive(1'b1, 1'b0, 4'h0, 11'h000, 32'h0, 1'b0, 4'h0, 11'h000, 32'h0);
        mcheck(11'h7FF, 32'h11111111, "cwr_mem");
        step(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, "cwr_idle");

        // Starvation: 8 refused cycles then a 4-beat locked burst
        drive(1'b1, 1'b1, 4'h0, 11'h005, 32'h0, 1'b1, 4'h0, 11'h020, 32'h0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, 4'h0, 1'b0, "t2_wait");
        for (int b = 0; b < 4; b++) begin
            dma_addr = 11'h020 + 11'(b);
            rd_q.push_back(32'hA0A0A0A0 + 32'h01010101 * 32'(b));
            step(1'b1, 1'b1, 1'b1, 4'h0, (b != 0), "t2_beat");
        end
        drive(1'b1, 1'b1, 4'h0, 11'h005, 32'h0, 1'b0, 4'h0, 11'h000, 32'h0);
        step(1'b0, 1'b0, 1'b1, 4'h0, 1'b1, "t2_release");
        drive(1'b1, 1'b0, 4'h0, 11'h000, 32'h0, 1'b0, 4'h0, 11'h000, 32'h0);
        step(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, "t2_idle");

        // Burst cut short after 2 beats; stalled CPU writes to the shared address are dropped
        drive(1'b1, 1'b1, 4'h0, 11'h7FF, 32'h0, 1'b1, 4'h0, 11'h7FF, 32'h0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, 4'h0, 1'b0, "t3_wait");
        cpu_we = 4'hF;
        cpu_wdata = 32'h22222222;
        rd_q.push_back(32'h11111111);
        step(1'b1, 1'b1, 1'b1, 4'h0, 1'b0, "t3_b1");
        rd_q.push_back(32'h11111111);
        step(1'b1, 1'b1, 1'b1, 4'h0, 1'b1, "t3_b2");
        dma_req = 1'b0;
        step(1'b0, 1'b1, 1'b0, 4'h0, 1'b1, "t3_drop");
        cpu_we = 4'h0;
        mcheck(11'h7FF, 32'h11111111, "t3_mem_kept");
        step(1'b0, 1'b0, 1'b1, 4'h0, 1'b0, "t3_cpu_go");
        drive(1'b1, 1'b0, 4'h0, 11'h000, 32'h0, 1'b0, 4'h0, 11'h000, 32'h0);
        step(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, "t3_idle");

        // Reset during beat 2 abandons the burst and clears the wait counter
        drive(1'b1, 1'b1, 4'h0, 11'h005, 32'h0, 1'b1, 4'h0, 11'h020, 32'h0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, 4'h0, 1'b0, "t5_wait");
        rd_q.push_back(32'hA0A0A0A0);
        step(1'b1, 1'b1, 1'b1, 4'h0, 1'b0, "t5_b1");
        rst_n = 1'b0;
        step(1'b0, 1'b0, 1'b0, 4'h0, 1'b1, "t5_rst");
        rst_n = 1'b1;
        zchk_next = 1'b1;
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, 4'h0, 1'b0, "t5_rewait");
        rd_q.push_back(32'hA0A0A0A0);
        step(1'b1, 1'b1, 1'b1, 4'h0, 1'b0, "t5_force");
        dma_req = 1'b0;
        step(1'b0, 1'b1, 1'b0, 4'h0, 1'b1, "t5_exit");
        drive(1'b1, 1'b0, 4'h0, 11'h000, 32'h0, 1'b0, 4'h0, 11'h000, 32'h0);
        step(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, "t5_idle");

        done = 1'b1;
    end

endmodule
